md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Multiply/divide scheduler in the EX stage.
- Accepts one MULT/MULTU/DIV/DIVU request at a time from EX and sequences the fixed-latency multiplier and the start/ready iterative divider.
- Holds the pipeline via a stall request until the result exists.
- Issues exactly one HI/LO write per committed instruction.
- Absorbs downstream stalls and annulment without losing or duplicating results.

Parameters:
- MUL_LATENCY, 2: cycles from operands presented on mul_ina/mul_inb to a valid mul_result; legal range 1-15.
- CNT_W, 4: width of the multiply latency counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  EX holds a mul/div instruction
- req_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op_a  in  32  rs value
- op_b  in  32  rt value
- annul  in  1  kill the current request/operation
- ex_stall  in  1  EX register not advancing this cycle (stall from a later stage)
- mul_signed  out  1  to multiplier
- mul_ina  out  32  to multiplier
- mul_inb  out  32  to multiplier
- mul_result  in  64  from multiplier, {hi,lo}
- div_start  out  1  to divider, held until ready
- div_signed  out  1  to divider
- div_opa  out  32  to divider
- div_opb  out  32  to divider
- div_annul  out  1  to divider, one-cycle abort pulse
- div_ready  in  1  divider result valid
- div_result  in  64  from divider, {remainder,quotient}
- stallreq  out  1  to stall controller
- hilo_we  out  1  HI/LO write enable
- hilo_data  out  64  {hi,lo}
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, MUL_WAIT, DIV_RUN, DONE, WAIT_ADV.
- Reset (resetn=0, asynchronous): state=IDLE, all operand/result registers 0, every output 0.
- Request acceptance: a request is accepted when state==IDLE, req_valid=1 and annul=0.
  - op_a, op_b and the signedness (req_op[0]==0 means signed) are latched.
  - stallreq=1 combinationally in the acceptance cycle.
- Multiply (req_op[1]==0): the counter loads MUL_LATENCY-1 and the state moves to MUL_WAIT.
  - mul_ina, mul_inb and mul_signed are driven from the latched registers; they are 0 in IDLE.
  - MUL_WAIT decrements the counter each cycle. At count 0, mul_result is captured into the result register and the state moves to DONE.
  - Total stall: MUL_LATENCY+1 cycles including the acceptance cycle.
- Divide (req_op[1]==1): the state moves to DIV_RUN.
  - div_start=1, with div_opa, div_opb and div_signed from the latched registers, while in DIV_RUN.
  - On the first DIV_RUN cycle with div_ready=1, div_result is captured and the state moves to DONE. div_start drops to 0 in that same cycle.
- stallreq is 1 when (IDLE & req_valid & ~annul), or in MUL_WAIT, or in DIV_RUN. It is 0 in DONE and WAIT_ADV.
- DONE lasts exactly one cycle: hilo_we=1 and hilo_data=result register. Otherwise hilo_we=0 and hilo_data=0.
  - Next state is IDLE if ex_stall=0, else WAIT_ADV.
- WAIT_ADV: req_valid is ignored, because the same instruction is still in EX. The state moves to IDLE on the first cycle with ex_stall=0. No second hilo_we is issued.
- annul in MUL_WAIT or DIV_RUN:
  - next state is IDLE, with no hilo_we;
  - div_annul=1 for that cycle when in DIV_RUN, and div_start=0;
  - stallreq=0 in that cycle.
- annul in IDLE blocks acceptance. annul in DONE suppresses hilo_we; the state goes directly to IDLE.
- div_ready=1 together with annul: annul wins, and the result is discarded.
- Divide by zero (feature disabled): handled through the divider like any other divide. The result is whatever the divider returns.
- Only one operation is ever outstanding; the multiplier and divider are never both active.

Optional Feature:
- MD_DIV0_FAST_EN:
  - When defined, a DIV/DIVU with op_b==0 at acceptance bypasses the divider: div_start stays 0.
  - The result register loads {op_a, 32'hFFFF_FFFF} and the state goes straight to DONE.
  - Stall lasts 1 cycle (the acceptance cycle only).
  - When undefined, zero divisors follow the normal DIV_RUN path.

Test Plan:
- MULT, op_a=-3, op_b=5, MUL_LATENCY=2 -> stallreq high for 3 cycles, then one hilo_we with hilo_data=64'hFFFF_FFFF_FFFF_FFF1.
- DIVU, op_a=100, op_b=7, divider ready after 34 cycles -> div_start held 34 cycles, stallreq drops the cycle after ready, hilo_data={32'd2,32'd14}, hilo_we exactly once.
- DIV completes while ex_stall=1 for 3 cycles with req_valid still 1 -> hilo_we exactly once, state WAIT_ADV, no restart; IDLE after ex_stall falls.
- annul on the 10th DIV_RUN cycle -> div_annul single pulse, no hilo_we, stallreq 0, next request accepted the following cycle.
- resetn low mid MUL_WAIT -> all outputs 0 immediately (asynchronous), state IDLE, no hilo_we after release.
- MD_DIV0_FAST_EN defined, DIV op_a=9, op_b=0 -> div_start never asserted, hilo_data={32'd9,32'hFFFF_FFFF} on the cycle after acceptance. Undefined -> divider path is used.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the EX stage.
// Accepts one MULT/MULTU/DIV/DIVU at a time, drives the fixed-latency
// multiplier or the start/ready divider, stalls EX until the result exists
// and issues exactly one HI/LO write per committed instruction.
// Optional feature macro: MD_DIV0_FAST_EN. When defined, a divide with a zero
// divisor completes without the divider, returning {op_a, 32'hFFFF_FFFF}.
module md_sched #(
    parameter int MUL_LATENCY = 2,  // operands-to-result cycles, 1..15
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        resetn,
    // request from EX
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        annul,
    input  logic        ex_stall,
    // multiplier
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    // divider
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    // pipeline / HI-LO
    output logic        stallreq,
    output logic        hilo_we,
    output logic [63:0] hilo_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_WAIT = 3'd1,
        DIV_RUN  = 3'd2,
        DONE     = 3'd3,
        WAIT_ADV = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LATENCY - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      opa_q, opb_q;
    logic             sgn_q;
    logic [63:0]      res_q, res_nxt;
    logic             accept;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            state <= state_nxt;
        end
    end

    // Operand latches, latency counter and result register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            opa_q <= '0;
            opb_q <= '0;
            sgn_q <= 1'b0;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            if (accept) begin
                opa_q <= op_a;
                opb_q <= op_b;
                sgn_q <= ~req_op[0];
            end
            cnt   <= cnt_nxt;
            res_q <= res_nxt;
        end
    end

    // Next-state logic and control outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        res_nxt   = res_q;
        accept    = 1'b0;
        stallreq  = 1'b0;
        hilo_we   = 1'b0;
        hilo_data = '0;
        div_start = 1'b0;
        div_annul = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && !annul) begin
                    accept   = 1'b1;
                    stallreq = 1'b1;
                    if (!req_op[1]) begin
                        state_nxt = MUL_WAIT;
                        cnt_nxt   = MUL_CNT_INIT;
                    end
`ifdef MD_DIV0_FAST_EN
                    else if (op_b == 32'd0) begin
                        // Zero divisor: skip the divider entirely.
                        state_nxt = DONE;
                        res_nxt   = {op_a, 32'hFFFF_FFFF};
                    end
`endif
                    else begin
                        state_nxt = DIV_RUN;
                    end
                end
            end

            MUL_WAIT: begin
                if (annul) begin
                    state_nxt = IDLE;
                end else begin
                    stallreq = 1'b1;
                    if (cnt == '0) begin
                        res_nxt   = mul_result;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end

            DIV_RUN: begin
                if (annul) begin
                    // Abort wins over a simultaneous div_ready.
                    div_annul = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stallreq = 1'b1;
                    if (div_ready) begin
                        res_nxt   = div_result;
                        state_nxt = DONE;
                    end else begin
                        div_start = 1'b1;
                    end
                end
            end

            DONE: begin
                if (annul) begin
                    state_nxt = IDLE;
                end else begin
                    hilo_we   = 1'b1;
                    hilo_data = res_q;
                    state_nxt = ex_stall ? WAIT_ADV : IDLE;
                end
            end

            WAIT_ADV: begin
                // The finished instruction is still sitting in EX; its
                // req_valid must not start a second operation.
                if (!ex_stall) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands reach a functional unit only while that unit is in use, so
    // the multiplier and divider are never driven at the same time.
    assign mul_signed = (state == MUL_WAIT) ? sgn_q : 1'b0;
    assign mul_ina    = (state == MUL_WAIT) ? opa_q : 32'd0;
    assign mul_inb    = (state == MUL_WAIT) ? opb_q : 32'd0;
    assign div_signed = (state == DIV_RUN)  ? sgn_q : 1'b0;
    assign div_opa    = (state == DIV_RUN)  ? opa_q : 32'd0;
    assign div_opb    = (state == DIV_RUN)  ? opb_q : 32'd0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed scoreboard bench for md_sched.
// Includes a one-register-stage multiplier (MUL_LATENCY=2) and a divider that
// raises ready after 34 start cycles. Expected HI/LO values are pushed into a
// queue at issue time and a negedge monitor pops them on every hilo_we.
module tb_md_sched;

    localparam int MUL_LATENCY = 2;
    localparam int DIV_CYC     = 34;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        annul = 1'b0;
    logic        ex_stall = 1'b0;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul, div_ready;
    logic [31:0] div_opa, div_opb;
    logic [63:0] div_result;
    logic        stallreq, hilo_we, busy;
    logic [63:0] hilo_data;

    int total = 0;
    int bad = 0;
    int we_count = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    md_sched #(.MUL_LATENCY(MUL_LATENCY), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_op(req_op), .op_a(op_a), .op_b(op_b),
        .annul(annul), .ex_stall(ex_stall),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa),
        .div_opb(div_opb), .div_annul(div_annul), .div_ready(div_ready),
        .div_result(div_result),
        .stallreq(stallreq), .hilo_we(hilo_we), .hilo_data(hilo_data),
        .busy(busy)
    );

    // ---------------- functional-unit models ----------------
    function automatic logic [63:0] mul_model(input logic s, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] div_model(input logic s, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return {32'hD1D0_0000, a};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    logic [63:0] mul_pipe;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) mul_pipe <= '0;
        else         mul_pipe <= mul_model(mul_signed, mul_ina, mul_inb);
    end
    assign mul_result = mul_pipe;

    logic [5:0] dcnt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                             dcnt <= '0;
        else if (div_annul || dcnt == 6'(DIV_CYC)) dcnt <= '0;
        else if (div_start)                      dcnt <= dcnt + 6'd1;
    end
    assign div_ready  = (dcnt == 6'(DIV_CYC));
    assign div_result = div_model(div_signed, div_opa, div_opb);

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every HI/LO write must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && hilo_we) begin
            we_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL hilo_extra: got %h want no write", hilo_data);
            end else begin
                check("hilo_data", hilo_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        op_a      = a;
        op_b      = b;
    endtask

    // Count stalled cycles until stallreq drops; optionally let EX advance.
    task automatic wait_complete(input bit drop_req, output int stalls, output int starts);
        int guard;
        guard  = 0;
        stalls = 0;
        starts = 0;
        forever begin
            @(negedge clk);
            if (div_start) starts++;
            if (!stallreq) break;
            stalls++;
            guard++;
            if (guard > 200) begin
                total++;
                bad++;
                $display("FAIL timeout: stallreq stuck high");
                break;
            end
        end
        if (drop_req) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_data,
                          input int exp_stalls, input int exp_starts);
        int stalls, starts, w0;
        w0 = we_count;
        exp_q.push_back(exp_data);
        issue(op, a, b);
        wait_complete(1'b1, stalls, starts);
        check({name, "_stalls"}, 64'(stalls), 64'(exp_stalls));
        check({name, "_starts"}, 64'(starts), 64'(exp_starts));
        check({name, "_we_once"}, 64'(we_count - w0), 64'd1);
        @(negedge clk);
        check({name, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int stalls, starts, w0;

        // Reset state.
        #1 resetn = 1'b0;
        #2;
        check("reset_ctl", {57'd0, stallreq, busy, hilo_we, div_start, div_annul,
                            mul_signed, div_signed}, 64'd0);
        check("reset_hilo", hilo_data, 64'd0);
        check("reset_ops", {mul_ina, div_opa}, 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Multiplies: stall is MUL_LATENCY+1 cycles.
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 3, 0);
        run_op("multu_big", 2'b01, 32'hFFFF_FFFF, 32'd2,        64'h0000_0001_FFFF_FFFE, 3, 0);
        run_op("mult_max",  2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 3, 0);
        run_op("mult_nn",   2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006, 3, 0);

        // Divides: 1 accept + 34 start cycles + 1 ready cycle.
        run_op("divu",      2'b11, 32'd100, 32'd7,               64'h0000_0002_0000_000E, 36, 34);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 36, 34);
`ifdef MD_DIV0_FAST_EN
        run_op("div0",      2'b10, 32'd9, 32'd0,                 64'h0000_0009_FFFF_FFFF, 1, 0);
`else
        run_op("div0",      2'b10, 32'd9, 32'd0,                 64'hD1D0_0000_0000_0009, 36, 34);
`endif

        // annul in IDLE blocks acceptance.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b00; op_a = 32'd4; op_b = 32'd4; annul = 1'b1;
        @(negedge clk);
        check("annul_idle_stall", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1;
        annul = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("annul_idle_busy", {63'd0, busy}, 64'd0);

        // annul in DONE suppresses the write.
        w0 = we_count;
        issue(2'b00, 32'd2, 32'd3);
        repeat (3) @(negedge clk);           // accept + two MUL_WAIT cycles
        @(posedge clk); #1;
        annul = 1'b1;
        @(negedge clk);
        check("annul_done", {61'd0, hilo_we, busy, stallreq}, 64'b010);
        @(posedge clk); #1;
        annul = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("annul_done_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check("annul_done_nowe", 64'(we_count - w0), 64'd0);

        // Completion under downstream stall: one write, then WAIT_ADV.
        w0 = we_count;
        exp_q.push_back(64'h0000_0002_0000_0006);
        issue(2'b10, 32'd20, 32'd3);
        ex_stall = 1'b1;
        wait_complete(1'b0, stalls, starts);
        check("exs_done_we", {63'd0, hilo_we}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("exs_wait_adv", {60'd0, busy, stallreq, div_start, hilo_we}, 64'b1000);
        end
        @(posedge clk); #1;
        ex_stall = 1'b0;
        @(negedge clk);
        check("exs_last_wait", {62'd0, busy, hilo_we}, 64'b10);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("exs_we_once", 64'(we_count - w0), 64'd1);
        @(negedge clk);
        check("exs_idle", {63'd0, busy}, 64'd0);

        // annul on the 10th DIV_RUN cycle, next request right after.
        w0 = we_count;
        issue(2'b11, 32'd50, 32'd5);
        @(negedge clk);                       // acceptance cycle
        repeat (9) @(negedge clk);            // DIV_RUN cycles 1..9
        check("annul_div_pre", {62'd0, div_start, stallreq}, 64'b11);
        @(posedge clk); #1;
        annul = 1'b1;
        @(negedge clk);
        check("annul_div", {60'd0, div_annul, div_start, stallreq, hilo_we}, 64'b1000);
        @(posedge clk); #1;
        annul = 1'b0;
        req_op = 2'b00; op_a = 32'd6; op_b = 32'd7;
        exp_q.push_back(64'd42);
        @(negedge clk);
        check("annul_next_accept", {61'd0, stallreq, div_annul, busy}, 64'b100);
        wait_complete(1'b1, stalls, starts);
        check("annul_next_stalls", 64'(stalls), 64'(MUL_LATENCY));
        check("annul_next_we", 64'(we_count - w0), 64'd1);

        // Asynchronous reset in the middle of MUL_WAIT.
        w0 = we_count;
        issue(2'b00, 32'd3, 32'd3);
        @(negedge clk);                       // acceptance
        @(posedge clk); #1;
        check("rst_mid_busy", {62'd0, busy, mul_signed}, 64'b11);
        resetn = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_mid_ctl", {57'd0, stallreq, busy, hilo_we, div_start, div_annul,
                              mul_signed, div_signed}, 64'd0);
        check("rst_mid_mul", {mul_ina, mul_inb}, 64'd0);
        check("rst_mid_hilo", hilo_data, 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_nowe", 64'(we_count - w0), 64'd0);
        check("rst_mid_idle", {63'd0, busy}, 64'd0);

        // Normal operation after reset.
        run_op("multu_post", 2'b01, 32'd3, 32'd4, 64'd12, 3, 0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
